// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, a radix-2 Booth multiplier and a
// restoring divider behind a start/busy/done handshake. Results are held in registers.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Zhighout,
  output logic [WIDTH-1:0] Zlowout,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_ADJ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_zhi;
  logic [WIDTH-1:0] r_zlo;
  logic             r_dbz;
  logic             r_illegal;

  // Booth engine: hi part carries one guard bit so adding/subtracting the most-negative
  // multiplicand never overflows.
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_mhi;
  logic [WIDTH-1:0] r_mlo;
  logic             r_mq;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_dsor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_bzero;

  logic [SHAMT_W-1:0] w_shamt;
  logic [SHAMT_W-1:0] w_rol_amt;
  logic [WIDTH-1:0]   w_ror;
  logic [WIDTH-1:0]   w_rol;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_legal;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_bsum;
  logic [WIDTH:0]     w_mhi_next;
  logic [WIDTH-1:0]   w_mlo_next;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_shamt   = B[SHAMT_W-1:0];
  // A left rotate is a right rotate by the complementary amount.
  assign w_rol_amt = SHAMT_W'(0) - w_shamt;
  assign w_ror     = WIDTH'({A, A} >> w_shamt);
  assign w_rol     = WIDTH'({A, A} >> w_rol_amt);

  always_comb begin
    w_alu_res   = '0;
    w_alu_legal = 1'b1;
    case (opcode)
      OP_AND:  w_alu_res = A & B;
      OP_OR:   w_alu_res = A | B;
      OP_ADD:  w_alu_res = A + B;
      OP_SUB:  w_alu_res = A - B;
      OP_SHR:  w_alu_res = A >> w_shamt;
      OP_SHRA: w_alu_res = WIDTH'($signed(A) >>> w_shamt);
      OP_SHL:  w_alu_res = A << w_shamt;
      OP_ROR:  w_alu_res = w_ror;
      OP_ROL:  w_alu_res = w_rol;
      OP_NEG:  w_alu_res = '0 - B;
      OP_NOT:  w_alu_res = ~B;
      OP_MUL, OP_DIV: w_alu_res = '0;
      default: w_alu_legal = 1'b0;
    endcase
  end

  assign w_m_ext = {r_m[WIDTH-1], r_m};

  always_comb begin
    w_bsum = r_mhi;
    case ({r_mlo[0], r_mq})
      2'b01:   w_bsum = r_mhi + w_m_ext;
      2'b10:   w_bsum = r_mhi - w_m_ext;
      default: w_bsum = r_mhi;
    endcase
  end

  assign w_mhi_next = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
  assign w_mlo_next = {w_bsum[0], r_mlo[WIDTH-1:1]};

  assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shifted - {1'b0, r_dsor};
  assign w_rem_next = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  assign w_abs_a = A[WIDTH-1] ? ('0 - A) : A;
  assign w_abs_b = B[WIDTH-1] ? ('0 - B) : B;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (opcode == OP_MUL)      w_state_next = S_MUL;
          else if (opcode == OP_DIV) w_state_next = S_DIV;
          else                       w_state_next = S_DONE;
        end
      end
      S_MUL:  if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
      S_DIV:  if (r_cnt == CNT_W'(1)) w_state_next = S_ADJ;
      S_ADJ:  w_state_next = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt     <= '0;
      r_z       <= '0;
      r_zhi     <= '0;
      r_zlo     <= '0;
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
      r_m       <= '0;
      r_mhi     <= '0;
      r_mlo     <= '0;
      r_mq      <= 1'b0;
      r_a       <= '0;
      r_dsor    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_bzero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= CNT_W'(WIDTH);
            if (opcode == OP_MUL) begin
              r_m   <= A;
              r_mhi <= '0;
              r_mlo <= B;
              r_mq  <= 1'b0;
            end else if (opcode == OP_DIV) begin
              r_a     <= A;
              r_dsor  <= w_abs_b;
              r_quo   <= w_abs_a;
              r_rem   <= '0;
              r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
              r_neg_r <= A[WIDTH-1];
              r_bzero <= (B == '0);
            end else begin
              // Single-cycle ops and illegal opcodes complete on this edge.
              if (w_alu_legal) r_z <= w_alu_res;
              r_illegal <= ~w_alu_legal;
              r_dbz     <= 1'b0;
            end
          end
        end
        S_MUL: begin
          r_mhi <= w_mhi_next;
          r_mlo <= w_mlo_next;
          r_mq  <= r_mlo[0];
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_zhi     <= w_mhi_next[WIDTH-1:0];
            r_zlo     <= w_mlo_next;
            r_illegal <= 1'b0;
            r_dbz     <= 1'b0;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_ADJ: begin
          r_illegal <= 1'b0;
          r_dbz     <= r_bzero;
          if (r_bzero) begin
            r_zlo <= '1;
            r_zhi <= r_a;
          end else begin
            r_zlo <= r_neg_q ? ('0 - r_quo) : r_quo;
            r_zhi <= r_neg_r ? ('0 - r_rem) : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign Z           = r_z;
  assign Zhighout    = r_zhi;
  assign Zlowout     = r_zlo;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32 and WIDTH=8: directed cases plus random ops checked
// against an arithmetic reference model with its own copy of the held result registers.
module tb_seq_alu;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic        clk = 1'b0;
  logic        clear = 1'b0;

  logic        start32 = 1'b0;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dbz32, ill32;
  logic [31:0] z32, hi32, lo32;

  logic        start8 = 1'b0;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8, ill8;
  logic [7:0]  z8, hi8, lo8;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clock(clk), .clear(clear), .start(start32), .opcode(op32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .Z(z32), .Zhighout(hi32), .Zlowout(lo32),
    .div_by_zero(dbz32), .illegal_op(ill32)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clock(clk), .clear(clear), .start(start8), .opcode(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Z(z8), .Zhighout(hi8), .Zlowout(lo8),
    .div_by_zero(dbz8), .illegal_op(ill8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sh_z[2], sh_hi[2], sh_lo[2];
  logic [63:0] last_z, last_hi, last_lo;
  logic        last_dbz, last_ill;
  int          last_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input int w, input logic [63:0] v);
    longint t;
    t = longint'(v);
    if (v[w-1]) t = t - (longint'(1) << w);
    return t;
  endfunction

  // Reference: results from plain integer arithmetic; unwritten registers keep their value.
  function automatic void model(input int w, input logic [4:0] op, input logic [63:0] ai,
                                input logic [63:0] bi, inout logic [63:0] z,
                                inout logic [63:0] hi, inout logic [63:0] lo,
                                output logic dbz, output logic ill, output int lat);
    logic [63:0] m, a, b, p;
    int amt;
    longint q, r;
    m   = (64'd1 << w) - 64'd1;
    a   = ai & m;
    b   = bi & m;
    amt = int'(b % 64'(w));
    dbz = 1'b0;
    ill = 1'b0;
    lat = 1;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = (a + b) & m;
      OP_SUB:  z = (a - b) & m;
      OP_NEG:  z = (64'd0 - b) & m;
      OP_NOT:  z = ~b & m;
      OP_SHR:  z = a >> amt;
      OP_SHRA: z = 64'(sx(w, a) >>> amt) & m;
      OP_SHL:  z = (a << amt) & m;
      OP_ROR:  z = ((a >> amt) | (a << (w - amt))) & m;
      OP_ROL:  z = ((a << amt) | (a >> (w - amt))) & m;
      OP_MUL: begin
        p   = 64'(sx(w, a) * sx(w, b));
        lo  = p & m;
        hi  = (p >> w) & m;
        lat = w + 1;
      end
      OP_DIV: begin
        lat = w + 2;
        if (b == 64'd0) begin
          lo  = m;
          hi  = a;
          dbz = 1'b1;
        end else begin
          q  = sx(w, a) / sx(w, b);
          r  = sx(w, a) % sx(w, b);
          lo = 64'(q) & m;
          hi = 64'(r) & m;
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic sel_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  task automatic run_op(input int w, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b);
    int lat;
    @(negedge clk);
    if (w == 32) begin
      op32 = op; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1;
    end else begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    start8  = 1'b0;
    // Inputs after the start edge must not matter.
    op32 = 5'($urandom); a32 = $urandom; b32 = $urandom;
    op8  = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!sel_done(w) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    last_lat = lat;
    if (w == 32) begin
      last_z = 64'(z32); last_hi = 64'(hi32); last_lo = 64'(lo32);
      last_dbz = dbz32; last_ill = ill32;
    end else begin
      last_z = 64'(z8); last_hi = 64'(hi8); last_lo = 64'(lo8);
      last_dbz = dbz8; last_ill = ill8;
    end
    @(posedge clk);
  endtask

  task automatic do_op(input int w, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    int k, lat;
    logic d, i;
    logic [63:0] tz, th, tl;
    k  = (w == 8) ? 1 : 0;
    tz = sh_z[k]; th = sh_hi[k]; tl = sh_lo[k];
    model(w, op, a, b, tz, th, tl, d, i, lat);
    sh_z[k] = tz; sh_hi[k] = th; sh_lo[k] = tl;
    run_op(w, op, a, b);
    $display("w=%0d op=%b a=%h b=%h -> z=%h hi=%h lo=%h dbz=%b ill=%b lat=%0d",
             w, op, a, b, last_z, last_hi, last_lo, last_dbz, last_ill, last_lat);
    chk($sformatf("lat%0d_op%b", w, op), 64'(last_lat), 64'(lat));
    chk($sformatf("z%0d_op%b", w, op), last_z, tz);
    chk($sformatf("hi%0d_op%b", w, op), last_hi, th);
    chk($sformatf("lo%0d_op%b", w, op), last_lo, tl);
    chk($sformatf("dbz%0d_op%b", w, op), 64'(last_dbz), 64'(d));
    chk($sformatf("ill%0d_op%b", w, op), 64'(last_ill), 64'(i));
  endtask

  logic [4:0] op_tab[15];

  initial begin
    int pulses, cnt, lat, w;
    logic d, i;
    logic [63:0] tz, th, tl, ra, rb;
    for (int k = 0; k < 2; k++) begin
      sh_z[k] = '0; sh_hi[k] = '0; sh_lo[k] = '0;
    end
    op_tab = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR, OP_SHRA, OP_SHL,
               OP_ROR, OP_ROL, OP_NEG, OP_NOT, 5'b11111, 5'b00000};

    #12;
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_z", 64'(z32), 64'd0);
    @(negedge clk);
    clear = 1'b1;

    // Abort a multiply with clear in its fifth cycle.
    do_op(32, OP_ADD, 64'd7, 64'd5);
    do_op(32, OP_MUL, 64'd3, 64'd5);
    @(negedge clk);
    op32 = OP_MUL; a32 = 32'hFFFF_FFFD; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (4) @(posedge clk);
    #3 clear = 1'b0;
    #1;
    chk("abort_busy", 64'(busy32), 64'd0);
    chk("abort_done", 64'(done32), 64'd0);
    chk("abort_z", 64'(z32), 64'd0);
    chk("abort_hi", 64'(hi32), 64'd0);
    chk("abort_lo", 64'(lo32), 64'd0);
    for (int k = 0; k < 2; k++) begin
      sh_z[k] = '0; sh_hi[k] = '0; sh_lo[k] = '0;
    end
    @(negedge clk);
    clear = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    do_op(32, OP_ADD, 64'd7, 64'd5);
    chk("add_7_5", last_z, 64'd12);

    do_op(32, OP_AND, 64'hF0F0_FFFF, 64'h0FF0_00FF);
    chk("and32", last_z, 64'h00F0_00FF);
    do_op(32, OP_SUB, 64'd3, 64'd5);
    chk("sub32", last_z, 64'hFFFF_FFFE);
    do_op(32, OP_SHRA, 64'h8000_0000, 64'h21);
    chk("shra32", last_z, 64'hC000_0000);
    do_op(32, OP_ROL, 64'h8000_0001, 64'd4);
    chk("rol32", last_z, 64'h0000_0018);
    do_op(32, OP_NEG, 64'd0, 64'd1);
    chk("neg32", last_z, 64'hFFFF_FFFF);
    do_op(32, OP_MUL, 64'hFFFF_FFFD, 64'd7);
    chk("mul32_prod", {last_hi[31:0], last_lo[31:0]}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul32_lat", 64'(last_lat), 64'd33);
    do_op(32, OP_MUL, 64'h8000_0000, 64'h8000_0000);
    chk("mul32_minneg", {last_hi[31:0], last_lo[31:0]}, 64'h4000_0000_0000_0000);
    do_op(32, OP_DIV, 64'hFFFF_FFF9, 64'd2);
    chk("div32_q", last_lo, 64'hFFFF_FFFD);
    chk("div32_r", last_hi, 64'hFFFF_FFFF);
    chk("div32_lat", 64'(last_lat), 64'd34);
    do_op(32, OP_DIV, 64'd9, 64'd0);
    chk("div0_q", last_lo, 64'hFFFF_FFFF);
    chk("div0_r", last_hi, 64'd9);
    chk("div0_flag", 64'(last_dbz), 64'd1);
    do_op(32, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF);
    chk("divovf_q", last_lo, 64'h8000_0000);
    chk("divovf_r", last_hi, 64'd0);

    // Start pulses during busy and during the done cycle must be ignored.
    tz = sh_z[0]; th = sh_hi[0]; tl = sh_lo[0];
    model(32, OP_MUL, 64'hFFFF_FFFD, 64'd7, tz, th, tl, d, i, lat);
    sh_z[0] = tz; sh_hi[0] = th; sh_lo[0] = tl;
    @(negedge clk);
    op32 = OP_MUL; a32 = 32'hFFFF_FFFD; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    cnt = 1;
    while (!done32 && cnt < 100) begin
      @(negedge clk);
      start32 = (cnt == 4); op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
      @(posedge clk);
      #1 start32 = 1'b0;
      cnt++;
    end
    chk("hs_lat", 64'(cnt), 64'(lat));
    chk("hs_z", 64'(z32), sh_z[0]);
    chk("hs_hi", 64'(hi32), sh_hi[0]);
    chk("hs_lo", 64'(lo32), sh_lo[0]);
    @(negedge clk);
    op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    chk("hs_done_ign_busy", 64'(busy32), 64'd0);
    @(posedge clk);
    #1;
    chk("hs_done_ign_done", 64'(done32), 64'd0);
    chk("hs_done_ign_z", 64'(z32), sh_z[0]);
    do_op(32, 5'b11111, 64'd1, 64'd2);
    chk("illegal_flag", 64'(last_ill), 64'd1);

    do_op(8, OP_AND, 64'hF0, 64'h3C);
    do_op(8, OP_SUB, 64'd3, 64'd5);
    chk("sub8", last_z, 64'hFE);
    do_op(8, OP_SHRA, 64'h80, 64'h21);
    chk("shra8", last_z, 64'hC0);
    do_op(8, OP_ROL, 64'h81, 64'd4);
    chk("rol8", last_z, 64'h18);
    do_op(8, OP_NEG, 64'd0, 64'd1);
    chk("neg8", last_z, 64'hFF);
    do_op(8, OP_MUL, 64'hFD, 64'd7);
    chk("mul8_prod", {last_hi[55:0], last_lo[7:0]}, 64'hFFEB);
    chk("mul8_lat", 64'(last_lat), 64'd9);
    do_op(8, OP_MUL, 64'h80, 64'h80);
    chk("mul8_minneg", {last_hi[55:0], last_lo[7:0]}, 64'h4000);
    do_op(8, OP_DIV, 64'hF9, 64'd2);
    chk("div8_q", last_lo, 64'hFD);
    chk("div8_r", last_hi, 64'hFF);
    chk("div8_lat", 64'(last_lat), 64'd10);
    do_op(8, OP_DIV, 64'd9, 64'd0);
    chk("div8_0_q", last_lo, 64'hFF);
    do_op(8, OP_DIV, 64'h80, 64'hFF);
    chk("div8_ovf_q", last_lo, 64'h80);

    for (int n = 0; n < 80; n++) begin
      w  = (n % 2 == 0) ? 32 : 8;
      ra = 64'($urandom);
      rb = 64'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      if ($urandom_range(0, 3) == 0) rb = rb % 64'd9;
      do_op(w, op_tab[$urandom_range(0, 14)], ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
